// File: rtl/noc_pkg.sv
// Shared definitions for the NoC input unit: flit field offsets and route labels.
package noc_pkg;

  localparam int DATASIZE = 40;

  // Flit field offsets (LSB positions) and widths
  localparam int SRC_LSB  = 36;
  localparam int SRC_W    = 4;
  localparam int DST_LSB  = 32;
  localparam int DSTX_LSB = 34;
  localparam int DSTY_LSB = 32;
  localparam int DXY_W    = 2;
  localparam int TS_LSB   = 24;
  localparam int TS_W     = 8;
  localparam int DATA_LSB = 2;
  localparam int DATA_W   = 22;
  localparam int TYPE_LSB = 0;
  localparam int TYPE_W   = 2;

  // One-hot output-port request labels
  localparam logic [3:0] LBL_NONE = 4'b0000;
  localparam logic [3:0] LBL_L    = 4'b0001;
  localparam logic [3:0] LBL_N    = 4'b0010;
  localparam logic [3:0] LBL_S    = 4'b0100;
  localparam logic [3:0] LBL_W    = 4'b1000;

endpackage

// File: rtl/flit_fifo.sv
// Flit buffer: DEPTH-entry circular FIFO with occupancy count and registered full.
module flit_fifo import noc_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3,
  parameter int DW    = noc_pkg::DATASIZE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full,
  output logic [WIDTH:0] count
);

  logic [DW-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic             full_q;
  logic             do_push, do_pop;

  // A push offered while full is dropped; the sender holds it
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty;
  assign empty   = (cnt_q == '0);
  assign full    = full_q;
  assign count   = cnt_q;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Occupancy next-state: simultaneous push and pop leaves it unchanged
  always_comb begin
    cnt_d = cnt_q + (WIDTH+1)'(do_push) - (WIDTH+1)'(do_pop);
  end

  // Pointers, count and full flag; pointers wrap naturally at 2^WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == (WIDTH+1)'(DEPTH));
    end
  end

  // Storage array; contents are masked by empty, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/noc_input_unit.sv
// Router input port: buffers flits, XY-routes the head flit, drops East-bound flits.
module noc_input_unit import noc_pkg::*; #(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = noc_pkg::DATASIZE,
  parameter int LOC_X    = 3,
  parameter int LOC_Y    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                data_valid,
  input  logic [DATASIZE-1:0] data_in,
  output logic                full,
  output logic [3:0]          label,
  output logic [DATASIZE-1:0] data_out,
  input  logic                ready,
  output logic                route_err
);

  localparam logic [DXY_W-1:0] LX = DXY_W'(LOC_X);
  localparam logic [DXY_W-1:0] LY = DXY_W'(LOC_Y);

  logic [DATASIZE-1:0] head;
  logic                empty;
  logic                illegal;
  logic                pop;
  logic [WIDTH:0]      count;
  logic [DXY_W-1:0]    dx, dy;

  flit_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DW(DATASIZE)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (data_valid),
    .pop   (pop),
    .wdata (data_in),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign dx = head[DSTX_LSB +: DXY_W];
  assign dy = head[DSTY_LSB +: DXY_W];

  // XY route of the head flit: x first, then y; x beyond us would need East
  always_comb begin
    label   = LBL_NONE;
    illegal = 1'b0;
    if (!empty) begin
      if (dx < LX)      label   = LBL_W;
      else if (dx > LX) illegal = 1'b1;
      else if (dy > LY) label   = LBL_N;
      else if (dy < LY) label   = LBL_S;
      else              label   = LBL_L;
    end
  end

  // Granted heads leave on ready; illegal heads are discarded unconditionally
  assign pop       = (ready && (label != LBL_NONE)) || illegal;
  assign route_err = illegal;
  assign data_out  = head;

  logic unused_ok;
  assign unused_ok = ^count;

endmodule

// File: tb/tb_noc_input_unit.sv
// Directed bench for noc_input_unit: one instance at (3,0), one at (1,1).
module tb_noc_input_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dv, rdy, full, rerr;
  logic [39:0] din, dout;
  logic [3:0]  lbl;
  logic        dv2, rdy2, full2, rerr2;
  logic [39:0] din2, dout2;
  logic [3:0]  lbl2;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  noc_input_unit #(.LOC_X(3), .LOC_Y(0)) dut (
    .clk(clk), .rst_n(rst_n), .data_valid(dv), .data_in(din), .full(full),
    .label(lbl), .data_out(dout), .ready(rdy), .route_err(rerr)
  );

  noc_input_unit #(.LOC_X(1), .LOC_Y(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_valid(dv2), .data_in(din2), .full(full2),
    .label(lbl2), .data_out(dout2), .ready(rdy2), .route_err(rerr2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] mk(input logic [3:0] dst, input logic [21:0] d);
    return {4'h5, dst, 8'hA5, d, 2'b01};
  endfunction

  logic [39:0] q[$];
  logic [39:0] f, a, b, ninth;

  initial begin
    rst_n = 1'b0; dv = 0; rdy = 0; din = '0; dv2 = 0; rdy2 = 0; din2 = '0;
    #12;
    chk("rst_full",  full, 0);
    chk("rst_label", lbl, 0);
    chk("rst_dout",  dout, 0);
    chk("rst_err",   rerr, 0);
    chk("rst_cnt",   dut.u_fifo.count, 0);
    rst_n = 1'b1;
    tick();

    // Local delivery and pop
    f = mk(4'b1100, 22'h1); dv = 1; din = f; tick(); dv = 0;
    chk("L_label", lbl, 4'b0001);
    chk("L_dout",  dout, f);
    rdy = 1; tick(); rdy = 0;
    chk("L_pop_label", lbl, 0);
    chk("L_pop_dout",  dout, 0);

    // West then North, order preserved
    a = mk(4'b0100, 22'h2); b = mk(4'b1110, 22'h3);
    dv = 1; din = a; tick(); din = b; tick(); dv = 0;
    chk("W_label", lbl, 4'b1000);
    chk("W_dout",  dout, a);
    chk("cnt2",    dut.u_fifo.count, 2);
    rdy = 1; tick();
    chk("N_label", lbl, 4'b0010);
    chk("N_dout",  dout, b);
    tick(); rdy = 0;
    chk("empty_label", lbl, 0);

    // Fill to full, hold off a ninth flit, free one slot
    dv = 1;
    for (int i = 0; i < 8; i++) begin din = mk(4'b1100, 22'h100 + 22'(i)); tick(); end
    chk("full_set", full, 1);
    chk("full_cnt", dut.u_fifo.count, 8);
    chk("full_head", dout, mk(4'b1100, 22'h100));
    ninth = mk(4'b1100, 22'h1FF); din = ninth; tick();
    chk("full_block_cnt", dut.u_fifo.count, 8);
    rdy = 1; tick(); rdy = 0;
    chk("full_clr", full, 0);
    chk("full_pop_cnt", dut.u_fifo.count, 7);
    tick(); dv = 0;
    chk("ninth_in_full", full, 1);
    rdy = 1;
    for (int i = 1; i < 9; i++) begin
      chk("drain", dout, (i == 8) ? ninth : mk(4'b1100, 22'h100 + 22'(i)));
      tick();
    end
    rdy = 0;
    chk("drain_cnt", dut.u_fifo.count, 0);

    // Second router at (1,1): S, N, W, discard
    dv2 = 1; din2 = mk(4'b0100, 22'h10); tick(); dv2 = 0;
    chk("S_label", lbl2, 4'b0100);
    chk("S_err",   rerr2, 0);
    rdy2 = 1; dv2 = 1; din2 = mk(4'b0111, 22'h11); tick();
    chk("N2_label", lbl2, 4'b0010);
    din2 = mk(4'b0001, 22'h12); tick(); dv2 = 0;
    chk("W2_label", lbl2, 4'b1000);
    tick(); rdy2 = 0;
    chk("d2_empty", dut2.u_fifo.count, 0);
    dv2 = 1; din2 = mk(4'b1001, 22'h13); tick(); dv2 = 0;
    chk("err_pulse", rerr2, 1);
    chk("err_label", lbl2, 0);
    tick();
    chk("err_gone",  rerr2, 0);
    chk("err_cnt",   dut2.u_fifo.count, 0);
    dv2 = 1; din2 = mk(4'b1001, 22'h14); tick();
    din2 = mk(4'b1101, 22'h15); tick();
    chk("err_b2b", rerr2, 1);
    din2 = mk(4'b0101, 22'h16); tick(); dv2 = 0;
    chk("err_b2b_end", rerr2, 0);
    chk("L2_label", lbl2, 4'b0001);
    chk("L2_dout",  dout2, mk(4'b0101, 22'h16));

    // Steady push+pop at count 4 with pointer wrap
    dv = 1;
    for (int i = 0; i < 4; i++) begin
      f = mk(4'b1100, 22'h200 + 22'(i)); din = f; q.push_back(f); tick();
    end
    rdy = 1;
    for (int i = 0; i < 20; i++) begin
      f = mk(4'b1100, 22'h300 + 22'(i)); din = f;
      chk("wrap_dout", dout, q[0]);
      tick();
      void'(q.pop_front()); q.push_back(f);
    end
    rdy = 0;
    chk("wrap_cnt", dut.u_fifo.count, 4);
    chk("wrap_head", dout, q[0]);
    din = mk(4'b1100, 22'h3FF); tick(); dv = 0;
    chk("five_cnt", dut.u_fifo.count, 5);

    // Asynchronous reset mid-cycle flushes everything
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt",   dut.u_fifo.count, 0);
    chk("arst_full",  full, 0);
    chk("arst_label", lbl, 0);
    chk("arst_dout",  dout, 0);
    #1 rst_n = 1'b1;
    rdy = 1; tick(); rdy = 0;
    chk("rdy_empty_cnt",   dut.u_fifo.count, 0);
    chk("rdy_empty_label", lbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
